ldr_writeback: RTL and testbench
================================

Name: ldr_writeback

Overview:
- Load-writeback stage sitting directly upstream of the register file's LDR write port (w_en_ldr / w_addr_ldr / w_data_ldr).
- Records the destination register of each issued LDR/LDRB in an in-order tag queue, pairs each returning memory read response with the oldest tag, and formats the data (word, or zero-extended byte).
- Drives the formatted result into the regfile one cycle after the response.
- Exports a pending-register mask so the issue/hazard logic can stall readers of in-flight load destinations.

Parameters:
- DEPTH, 4, max outstanding loads (power of 2, >=2)
- DATA_W, 32, data word width
- REG_W, 4, register index width (16 registers)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  load issue request
- issue_ready  out  1  tag queue can accept an issue
- issue_rd  in  REG_W  load destination register
- issue_byte  in  1  1 = LDRB, 0 = LDR
- issue_off  in  2  byte offset (address[1:0]), used only for LDRB
- mem_rvalid  in  1  memory read response valid (no backpressure)
- mem_rdata  in  DATA_W  memory read data
- w_en_ldr  out  1  regfile LDR write enable
- w_addr_ldr  out  REG_W  regfile LDR write address
- w_data_ldr  out  DATA_W  regfile LDR write data
- pending_mask  out  2**REG_W  bit r set while a load to r is outstanding
- busy  out  1  any tag queued or writeback in progress
- resp_err  out  1  sticky: response arrived with empty queue

Behaviour:
- Reset (rst high at a clock edge):
  - Queue emptied; pointers and count set to 0.
  - w_en_ldr=0, w_addr_ldr=0, w_data_ldr=0.
  - pending_mask=0, busy=0, resp_err=0.
  - issue_ready is 0 while rst is high.
- Reset mid-operation discards all tags and any pending writeback, with no write issued. Responses arriving after reset with an empty queue set resp_err.
- Issue:
  - Accepted on an edge where issue_valid && issue_ready.
  - Pushes {issue_rd, issue_byte, issue_off}.
  - issue_ready = !rst && count<DEPTH. There is no same-cycle bypass when full: issue_ready=0 at count==DEPTH even if mem_rvalid pops that cycle.
- Response:
  - On an edge with mem_rvalid=1 and count>0, the oldest tag is popped.
  - The writeback register loads on the same edge, so w_en_ldr is high for exactly the next cycle. Latency is 1 cycle from response.
  - Data formatting: LDR gives w_data_ldr = mem_rdata. LDRB gives w_data_ldr = {24'b0, mem_rdata[8*off +: 8]}.
  - rd==0: the tag pops, but w_en_ldr stays 0 (R0 reads as zero). w_addr_ldr/w_data_ldr still update.
  - Back-to-back responses give back-to-back single-cycle writes.
- mem_rvalid with count==0 (including the same cycle as an issue into an empty queue):
  - Response ignored.
  - resp_err set and held until rst.
  - Queue unchanged.
- Simultaneous push and pop with 0<count<DEPTH: both occur and count is unchanged. Pointers wrap modulo DEPTH.
- pending_mask:
  - OR over all valid queue entries' rd, plus w_addr_ldr while w_en_ldr=1.
  - Bit 0 is never set.
  - A bit clears the cycle after its final write (the regfile has then captured the value).
  - A pushed tag is visible in the mask the cycle after acceptance.
  - Multiple loads to the same rd keep the bit set until the last one writes.
- busy = (count!=0) || w_en_ldr.
- The block never drives the regfile's w_en1 / w_en2 ports. Ordering against those ports is the regfile's concern.

Decomposition:
- Shared package arm_pkg holds:
  - constants WORD_W=32, REG_W=4, NUM_REGS=16
  - typedef reg_idx_t
  - typedef struct ld_tag_t {rd, is_byte, off}
  - function ldr_format(data, tag)
- One sub-module, ld_tag_fifo: a synchronous FIFO of ld_tag_t with push, pop, full, empty, count, and a flat valid-entry view for the mask OR.
- Formatting, the writeback register, the mask and resp_err live in ldr_writeback.

Test Plan:
- Single load: issue rd=5 LDR; 3 cycles later mem_rvalid with rdata=32'hCAFEF00D → next cycle w_en_ldr=1, w_addr_ldr=5, w_data_ldr=32'hCAFEF00D. pending_mask[5] is high from the cycle after issue through the write cycle, then 0.
- Byte loads: four LDRB to rd=3, off=0..3; responses all 32'h44332211 → writes 32'h11, 32'h22, 32'h33, 32'h44 in order, on consecutive cycles.
- Fill and ordering: issue rd=1,2,3,4 → issue_ready=0 with count=4. An issue_valid held high is not accepted until after the first response. Writes occur to 1,2,3,4 in order; busy drops after the last write.
- Same-destination and R0: two LDR to rd=7, then one to rd=0 → pending_mask[7] stays high until the second write. The R0 response produces w_en_ldr=0 and mask bit 0 stays 0.
- Error and reset: mem_rvalid with empty queue → resp_err=1, no write. Issue rd=9, assert rst for one cycle before the response → all outputs 0. The response then arriving sets resp_err and no write occurs.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM core types: register indices, load tags and the load-data formatter.
package arm_pkg;

    localparam int WORD_W   = 32;
    localparam int REG_W    = 4;
    localparam int NUM_REGS = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t   rd;
        logic       is_byte;
        logic [1:0] off;
    } ld_tag_t;

    // LDRB picks the addressed byte lane and zero-extends it; LDR passes the word through.
    function automatic logic [WORD_W-1:0] ldr_format(input logic [WORD_W-1:0] data,
                                                     input ld_tag_t           tag);
        logic [WORD_W-1:0] res;
        if (tag.is_byte) begin
            res = {{(WORD_W-8){1'b0}}, data[{tag.off, 3'b000} +: 8]};
        end else begin
            res = data;
        end
        return res;
    endfunction

endpackage

// File: rtl/ldr_writeback_if.sv
// Issue, memory-response and regfile-writeback signals of the load-writeback stage.
interface ldr_writeback_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [REG_W-1:0]      issue_rd;
    logic                  issue_byte;
    logic [1:0]            issue_off;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  w_en_ldr;
    logic [REG_W-1:0]      w_addr_ldr;
    logic [DATA_W-1:0]     w_data_ldr;
    logic [2**REG_W-1:0]   pending_mask;
    logic                  busy;
    logic                  resp_err;

    modport slave (
        input  issue_valid, issue_rd, issue_byte, issue_off, mem_rvalid, mem_rdata,
        output issue_ready, w_en_ldr, w_addr_ldr, w_data_ldr, pending_mask, busy, resp_err
    );

    modport master (
        output issue_valid, issue_rd, issue_byte, issue_off, mem_rvalid, mem_rdata,
        input  issue_ready, w_en_ldr, w_addr_ldr, w_data_ldr, pending_mask, busy, resp_err
    );
endinterface

// File: rtl/ld_tag_fifo.sv
// In-order queue of outstanding load tags; exposes every slot so the owner can build a mask.
module ld_tag_fifo
    import arm_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  ld_tag_t               push_tag,
    input  logic                  pop,
    output ld_tag_t               pop_tag,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic [DEPTH-1:0]      ent_vld,
    output ld_tag_t [DEPTH-1:0]   ent_tag
);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DEPTH-1:0]     vld_q, vld_d;
    ld_tag_t [DEPTH-1:0]  mem_q, mem_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_tag = mem_q[rd_ptr_q];
    assign ent_vld = vld_q;
    assign ent_tag = mem_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        mem_d    = mem_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Slot contents are qualified by vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ldr_writeback.sv
// Load-writeback stage: pairs memory responses with queued LDR/LDRB tags and drives the regfile LDR port.
module ldr_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = arm_pkg::WORD_W,
    parameter int REG_W  = arm_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    ldr_writeback_if.slave    bus
);
    import arm_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 push, pop, full, empty;
    logic [CNT_W-1:0]     count;
    ld_tag_t              issue_tag, head_tag;
    logic [DEPTH-1:0]     ent_vld;
    ld_tag_t [DEPTH-1:0]  ent_tag;

    logic                 w_en_q, w_en_d;
    logic [REG_W-1:0]     w_addr_q, w_addr_d;
    logic [DATA_W-1:0]    w_data_q, w_data_d;
    logic                 resp_err_q, resp_err_d;
    logic [2**REG_W-1:0]  pending_mask_c;

    assign issue_tag = '{rd: bus.issue_rd, is_byte: bus.issue_byte, off: bus.issue_off};

    // Ready ignores a same-cycle pop on purpose: no bypass through a full queue.
    assign bus.issue_ready = !rst && !full;
    assign push            = bus.issue_valid && bus.issue_ready;
    assign pop             = bus.mem_rvalid && !empty;

    ld_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_tag (issue_tag),
        .pop      (pop),
        .pop_tag  (head_tag),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ent_vld  (ent_vld),
        .ent_tag  (ent_tag)
    );

    always_comb begin
        w_en_d     = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        resp_err_d = resp_err_q || (bus.mem_rvalid && empty);
        if (pop) begin
            // R0 is hard-wired zero: the tag retires but no write is enabled.
            w_en_d   = (head_tag.rd != '0);
            w_addr_d = head_tag.rd;
            w_data_d = ldr_format(bus.mem_rdata, head_tag);
        end
    end

    always_comb begin
        pending_mask_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                pending_mask_c[ent_tag[i].rd] = 1'b1;
            end
        end
        if (w_en_q) begin
            pending_mask_c[w_addr_q] = 1'b1;
        end
        pending_mask_c[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign bus.w_en_ldr     = w_en_q;
    assign bus.w_addr_ldr   = w_addr_q;
    assign bus.w_data_ldr   = w_data_q;
    assign bus.pending_mask = pending_mask_c;
    assign bus.busy         = (count != '0) || w_en_q;
    assign bus.resp_err     = resp_err_q;

endmodule

// File: tb/tb_ldr_writeback.sv
// Self-checking bench for ldr_writeback: directed vector table, corner sequences and random traffic vs a queue model.
module tb_ldr_writeback;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ldr_writeback_if #(.DATA_W(32), .REG_W(4)) bus ();

    ldr_writeback #(.DEPTH(DEPTH), .DATA_W(32), .REG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int rd;
        bit is_byte;
        int off;
    } m_tag_t;

    m_tag_t      mq[$];
    bit          m_wen;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        if (m_wen) m[m_waddr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock: drive inputs, check ready, clock the edge, advance model, check outputs.
    task automatic cycle(input bit r, input bit iv, input int rd, input bit b, input int off,
                         input bit rv, input logic [31:0] rdata);
        int     sz;
        m_tag_t t;
        rst             = r;
        bus.issue_valid = iv;
        bus.issue_rd    = rd[3:0];
        bus.issue_byte  = b;
        bus.issue_off   = off[1:0];
        bus.mem_rvalid  = rv;
        bus.mem_rdata   = rdata;
        #1;
        chk("issue_ready", bus.issue_ready, (!r && mq.size() < DEPTH));
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_wen   = 1'b0;
            m_waddr = 0;
            m_wdata = '0;
            m_err   = 1'b0;
        end else begin
            sz    = mq.size();
            m_wen = 1'b0;
            if (rv && sz > 0) begin
                t       = mq.pop_front();
                m_wen   = (t.rd != 0);
                m_waddr = t.rd;
                m_wdata = t.is_byte ? ((rdata >> (8 * t.off)) & 32'hFF) : rdata;
            end else if (rv) begin
                m_err = 1'b1;
            end
            if (iv && sz < DEPTH) mq.push_back('{rd, b, off});
        end
        #1;
        chk("w_en_ldr", bus.w_en_ldr, m_wen);
        chk("w_addr_ldr", bus.w_addr_ldr, m_waddr[3:0]);
        chk("w_data_ldr", bus.w_data_ldr, m_wdata);
        chk("pending_mask", bus.pending_mask, model_mask());
        chk("busy", bus.busy, (mq.size() != 0) || m_wen);
        chk("resp_err", bus.resp_err, m_err);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    typedef struct {
        bit          iv;
        int          rd;
        bit          b;
        int          off;
        bit          rv;
        logic [31:0] rdata;
        bit          e_wen;
        int          e_addr;
        logic [31:0] e_data;
        logic [15:0] e_mask;
        bit          e_busy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int exp_addr[4];
        logic [31:0] rdat;

        tbl[0]  = '{1, 5, 0, 0, 0, 32'h0,        0, 0, 32'h0,        16'h0020, 1};
        tbl[1]  = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        16'h0020, 1};
        tbl[2]  = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        16'h0020, 1};
        tbl[3]  = '{0, 0, 0, 0, 1, 32'hCAFEF00D, 1, 5, 32'hCAFEF00D, 16'h0020, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 32'h0,        0, 5, 32'hCAFEF00D, 16'h0000, 0};
        tbl[5]  = '{1, 3, 1, 0, 0, 32'h0,        0, 5, 32'hCAFEF00D, 16'h0008, 1};
        tbl[6]  = '{1, 3, 1, 1, 0, 32'h0,        0, 5, 32'hCAFEF00D, 16'h0008, 1};
        tbl[7]  = '{1, 3, 1, 2, 0, 32'h0,        0, 5, 32'hCAFEF00D, 16'h0008, 1};
        tbl[8]  = '{1, 3, 1, 3, 0, 32'h0,        0, 5, 32'hCAFEF00D, 16'h0008, 1};
        tbl[9]  = '{0, 0, 0, 0, 1, 32'h44332211, 1, 3, 32'h00000011, 16'h0008, 1};
        tbl[10] = '{0, 0, 0, 0, 1, 32'h44332211, 1, 3, 32'h00000022, 16'h0008, 1};
        tbl[11] = '{0, 0, 0, 0, 1, 32'h44332211, 1, 3, 32'h00000033, 16'h0008, 1};
        tbl[12] = '{0, 0, 0, 0, 1, 32'h44332211, 1, 3, 32'h00000044, 16'h0008, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 32'h0,        0, 3, 32'h00000044, 16'h0000, 0};

        // Reset state
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        cycle(1, 1, 6, 0, 0, 1, 32'h1);
        chk("rst_w_en", bus.w_en_ldr, 1'b0);
        chk("rst_mask", bus.pending_mask, 16'h0);

        // Single load and byte loads from the vector table
        for (int i = 0; i < 14; i++) begin
            cycle(0, tbl[i].iv, tbl[i].rd, tbl[i].b, tbl[i].off, tbl[i].rv, tbl[i].rdata);
            chk($sformatf("tbl%0d_wen", i), bus.w_en_ldr, tbl[i].e_wen);
            chk($sformatf("tbl%0d_addr", i), bus.w_addr_ldr, tbl[i].e_addr[3:0]);
            chk($sformatf("tbl%0d_data", i), bus.w_data_ldr, tbl[i].e_data);
            chk($sformatf("tbl%0d_mask", i), bus.pending_mask, tbl[i].e_mask);
            chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
        end

        // Fill: four loads, then a held issue that must wait past the first response
        for (int r = 1; r <= 4; r++) cycle(0, 1, r, 0, 0, 0, 32'h0);
        cycle(0, 1, 5, 0, 0, 0, 32'h0);
        cycle(0, 1, 5, 0, 0, 0, 32'h0);
        chk("fill_ready", bus.issue_ready, 1'b0);
        cycle(0, 1, 5, 0, 0, 1, 32'h1000_0001);
        chk("fill_first_addr", bus.w_addr_ldr, 4'd1);
        chk("fill_first_en", bus.w_en_ldr, 1'b1);
        cycle(0, 1, 5, 0, 0, 0, 32'h0);
        exp_addr = '{2, 3, 4, 5};
        for (int k = 0; k < 4; k++) begin
            rdat = 32'h2000_0000 + k;
            cycle(0, 0, 0, 0, 0, 1, rdat);
            chk($sformatf("drain%0d_addr", k), bus.w_addr_ldr, exp_addr[k][3:0]);
            chk($sformatf("drain%0d_data", k), bus.w_data_ldr, rdat);
        end
        idle();
        chk("drain_busy", bus.busy, 1'b0);

        // Same destination twice, then R0
        cycle(0, 1, 7, 0, 0, 0, 32'h0);
        cycle(0, 1, 7, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 0, 0, 1, 32'hAAAA_0001);
        chk("same_rd_mask7_a", bus.pending_mask[7], 1'b1);
        cycle(0, 0, 0, 0, 0, 1, 32'hAAAA_0002);
        chk("same_rd_mask7_b", bus.pending_mask[7], 1'b1);
        chk("same_rd_data", bus.w_data_ldr, 32'hAAAA_0002);
        cycle(0, 0, 0, 0, 0, 1, 32'hBBBB_0000);
        chk("r0_wen", bus.w_en_ldr, 1'b0);
        chk("r0_mask7", bus.pending_mask[7], 1'b0);
        chk("r0_mask0", bus.pending_mask[0], 1'b0);
        idle();

        // Error on empty queue, then reset discarding an outstanding load
        cycle(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("err_set", bus.resp_err, 1'b1);
        chk("err_no_write", bus.w_en_ldr, 1'b0);
        idle();
        chk("err_sticky", bus.resp_err, 1'b1);
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        cycle(0, 1, 9, 0, 0, 0, 32'h0);
        chk("pre_rst_mask9", bus.pending_mask[9], 1'b1);
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        chk("rst_outs", {bus.w_en_ldr, bus.w_addr_ldr, bus.w_data_ldr, bus.busy, bus.resp_err},
            38'h0);
        chk("rst_mask_clr", bus.pending_mask, 16'h0);
        cycle(0, 0, 0, 0, 0, 1, 32'h9999_9999);
        chk("post_rst_err", bus.resp_err, 1'b1);
        chk("post_rst_no_write", bus.w_en_ldr, 1'b0);
        cycle(1, 0, 0, 0, 0, 0, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 15),
                  ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 9) < 4),
                  $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
